fsm_door_ctrl: RTL

FSM_DOOR_CTRL -- requirements
Module: fsm_door_ctrl

---
 rtl/fsm_door_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/fsm_door_ctrl.sv
// fsm_door_ctrl: garage-door motor controller with limit switches, obstruction reversal and run timeout.
// Define DOOR_AUTO_CLOSE_EN to compile in auto-close of a door left fully open.
module fsm_door_ctrl #(
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int AUTO_CLOSE_CYCLES = 5000,
  parameter int CNT_W             = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       UP_MAX,
  input  logic       DN_MAX,
  input  logic       OBSTRUCT,
  output logic       UP_motor,
  output logic       DN_motor,
  output logic       FAULT,
  output logic [2:0] STATE
);
`ifdef DOOR_AUTO_CLOSE_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] AC_LAST = CNT_W'(AUTO_CLOSE_CYCLES - 1);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MV_UP   = 3'd1,
    S_MV_DN   = 3'd2,
    S_STOPPED = 3'd3,
    S_FAULT   = 3'd4
  } state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_q, armed_q, last_up_q, last_up_d;
  logic             act_rise, idle_run, run;
  // armed_q blocks a spurious edge when Activate is already high as reset releases
  assign act_rise = Activate & ~act_q & armed_q;
  assign idle_run = AUTO_EN & (state_q == S_IDLE) & UP_MAX & ~OBSTRUCT;
  assign run      = (state_q == S_MV_UP) | (state_q == S_MV_DN) | idle_run;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (act_rise) state_d = UP_MAX ? S_MV_DN : S_MV_UP;
        else if (idle_run && cnt_q == AC_LAST) state_d = S_MV_DN;
      end
      S_MV_UP: begin
        if (UP_MAX) state_d = S_IDLE;
        else if (act_rise) state_d = S_STOPPED;
        else if (cnt_q == TO_LAST) state_d = S_FAULT;
      end
      S_MV_DN: begin
        if (DN_MAX) state_d = S_IDLE;
        else if (OBSTRUCT || act_rise) state_d = S_MV_UP;
        else if (cnt_q == TO_LAST) state_d = S_FAULT;
      end
      S_STOPPED: if (act_rise) state_d = last_up_q ? S_MV_DN : S_MV_UP;
      default: state_d = S_FAULT;
    endcase
    if (state_q != S_FAULT && UP_MAX && DN_MAX) state_d = S_FAULT;
    // any state change (including reversal) restarts the count from zero
    cnt_d = (run && state_d == state_q) ? (&cnt_q ? cnt_q : cnt_q + CNT_W'(1)) : '0;
    last_up_d = (state_q == S_MV_UP) ? 1'b1 : (state_q == S_MV_DN) ? 1'b0 : last_up_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      act_q     <= 1'b0;
      armed_q   <= 1'b0;
      last_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= Activate;
      armed_q   <= armed_q | ~Activate;
      last_up_q <= last_up_d;
    end
  end
  assign UP_motor = state_q == S_MV_UP;
  assign DN_motor = state_q == S_MV_DN;
  assign FAULT    = state_q == S_FAULT;
  assign STATE    = state_q;
endmodule
